// File: rtl/slant_lane_deframer.sv
// Receive-side lane deframer: decodes frame/line marker runs from the lane symbol
// stream and reassembles alternating Y/C data symbols into coordinate-tagged pairs.
module slant_lane_deframer #(
  parameter logic [23:0] FRAME1          = 24'hAAB155,
  parameter logic [23:0] FRAME0          = 24'hAA8D55,
  parameter logic [15:0] HSYNC           = 16'hA355,
  parameter int          PAIRS_PER_LINE  = 40,
  parameter int          LINES_PER_FRAME = 960
) (
  input  logic       Cclk,
  input  logic       rstn,
  input  logic [7:0] RxData,
  input  logic       RxStrobe,
  output logic       pix_valid,
  output logic [4:0] pix_y,
  output logic [4:0] pix_c,
  output logic [5:0] pix_x,
  output logic [9:0] pix_line,
  output logic       frame_start,
  output logic       frame_odd,
  output logic       line_start,
  output logic       frame_done,
  output logic       marker_err,
  output logic       len_err,
  output logic [1:0] dbg_state
);

  localparam logic [5:0] PPL       = 6'(PAIRS_PER_LINE);
  localparam logic [5:0] LAST_PAIR = 6'(PAIRS_PER_LINE - 1);
  localparam logic [9:0] LAST_LINE = 10'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] msr_q, msr_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic        in_frame_q, in_frame_d;
  logic [9:0]  line_q, line_d;
  logic [5:0]  pair_q, pair_d;
  logic        ph_q, ph_d;
  logic [4:0]  ylat_q, ylat_d;

  logic       pix_valid_d, frame_start_d, frame_odd_d, line_start_d;
  logic       frame_done_d, marker_err_d, len_err_d;
  logic [4:0] pix_y_d, pix_c_d;
  logic [5:0] pix_x_d;
  logic [9:0] pix_line_d;

  logic       is_mk, is_dat, is_ill, mk_bit;
  logic [4:0] payload, mcnt_inc;
  logic       frame_hit, hsync_hit;

  assign is_mk    = RxStrobe && (RxData == 8'hFF || RxData == 8'h01);
  assign is_dat   = RxStrobe && !RxData[7] && (RxData[1:0] == 2'b00);
  assign is_ill   = RxStrobe && !is_mk && !is_dat;
  assign mk_bit   = RxData[7];
  assign payload  = RxData[6:2];
  assign mcnt_inc = (mcnt_q == 5'd31) ? mcnt_q : mcnt_q + 5'd1;

  assign frame_hit = (mcnt_q == 5'd24) && (msr_q == FRAME1 || msr_q == FRAME0);
  // A line marker only counts inside a frame and only if another line remains.
  assign hsync_hit = (mcnt_q == 5'd16) && (msr_q[15:0] == HSYNC) && in_frame_q &&
                     (line_q < LAST_LINE);

  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    msr_d         = msr_q;
    mcnt_d        = mcnt_q;
    in_frame_d    = in_frame_q;
    line_d        = line_q;
    pair_d        = pair_q;
    ph_d          = ph_q;
    ylat_d        = ylat_q;
    pix_valid_d   = 1'b0;
    pix_y_d       = pix_y;
    pix_c_d       = pix_c;
    pix_x_d       = pix_x;
    pix_line_d    = pix_line;
    frame_start_d = 1'b0;
    frame_odd_d   = frame_odd;
    line_start_d  = 1'b0;
    frame_done_d  = 1'b0;
    marker_err_d  = 1'b0;
    len_err_d     = 1'b0;

    case (state_q)
      HUNT: begin
        if (is_mk) begin
          msr_d   = {23'd0, mk_bit};
          mcnt_d  = 5'd1;
          state_d = MARK;
        end
      end

      MARK: begin
        if (is_mk) begin
          msr_d  = {msr_q[22:0], mk_bit};
          mcnt_d = mcnt_inc;
        end else if (is_ill) begin
          marker_err_d = 1'b1;
          in_frame_d   = 1'b0;
          state_d      = HUNT;
        end else if (is_dat) begin
          // The data symbol that closes a valid run is already the Y of pair 0.
          if (frame_hit) begin
            frame_start_d = 1'b1;
            frame_odd_d   = (msr_q == FRAME1);
            in_frame_d    = 1'b1;
            line_d        = 10'd0;
            pair_d        = 6'd0;
            ylat_d        = payload;
            ph_d          = 1'b1;
            state_d       = DATA;
          end else if (hsync_hit) begin
            line_start_d = 1'b1;
            len_err_d    = (pair_q != PPL);
            line_d       = line_q + 10'd1;
            pair_d       = 6'd0;
            ylat_d       = payload;
            ph_d         = 1'b1;
            state_d      = DATA;
          end else begin
            marker_err_d = 1'b1;
            in_frame_d   = 1'b0;
            state_d      = HUNT;
          end
        end
      end

      DATA: begin
        if (is_dat) begin
          if (pair_q == PPL) begin
            len_err_d = 1'b1;
          end else if (!ph_q) begin
            ylat_d = payload;
            ph_d   = 1'b1;
          end else begin
            ph_d        = 1'b0;
            pix_valid_d = 1'b1;
            pix_y_d     = ylat_q;
            pix_c_d     = payload;
            pix_x_d     = pair_q;
            pix_line_d  = line_q;
            pair_d      = pair_q + 6'd1;
            if (pair_q == LAST_PAIR && line_q == LAST_LINE) begin
              frame_done_d = 1'b1;
              in_frame_d   = 1'b0;
              state_d      = HUNT;
            end
          end
        end else if (is_mk) begin
          len_err_d = ph_q;
          ph_d      = 1'b0;
          msr_d     = {23'd0, mk_bit};
          mcnt_d    = 5'd1;
          state_d   = MARK;
        end else if (is_ill) begin
          marker_err_d = 1'b1;
          in_frame_d   = 1'b0;
          state_d      = HUNT;
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      state_q     <= HUNT;
      msr_q       <= 24'd0;
      mcnt_q      <= 5'd0;
      in_frame_q  <= 1'b0;
      line_q      <= 10'd0;
      pair_q      <= 6'd0;
      ph_q        <= 1'b0;
      ylat_q      <= 5'd0;
      pix_valid   <= 1'b0;
      pix_y       <= 5'd0;
      pix_c       <= 5'd0;
      pix_x       <= 6'd0;
      pix_line    <= 10'd0;
      frame_start <= 1'b0;
      frame_odd   <= 1'b0;
      line_start  <= 1'b0;
      frame_done  <= 1'b0;
      marker_err  <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      msr_q       <= msr_d;
      mcnt_q      <= mcnt_d;
      in_frame_q  <= in_frame_d;
      line_q      <= line_d;
      pair_q      <= pair_d;
      ph_q        <= ph_d;
      ylat_q      <= ylat_d;
      pix_valid   <= pix_valid_d;
      pix_y       <= pix_y_d;
      pix_c       <= pix_c_d;
      pix_x       <= pix_x_d;
      pix_line    <= pix_line_d;
      frame_start <= frame_start_d;
      frame_odd   <= frame_odd_d;
      line_start  <= line_start_d;
      frame_done  <= frame_done_d;
      marker_err  <= marker_err_d;
      len_err     <= len_err_d;
    end
  end

endmodule

// File: tb/tb_slant_lane_deframer.sv
// Directed bench for slant_lane_deframer: a full-size lane (a) and a 2x2 lane (b)
// sharing RxData with separate strobes; pixels of lane a go through a scoreboard.
module tb_slant_lane_deframer;

  localparam logic [23:0] F1 = 24'hAAB155;
  localparam logic [23:0] F0 = 24'hAA8D55;
  localparam logic [23:0] HS = 24'h00A355;

  logic       Cclk, rstn;
  logic [7:0] RxData;
  logic       strobe_a, strobe_b;

  logic       pix_valid_a, frame_start_a, frame_odd_a, line_start_a;
  logic       frame_done_a, marker_err_a, len_err_a;
  logic [4:0] pix_y_a, pix_c_a;
  logic [5:0] pix_x_a;
  logic [9:0] pix_line_a;
  logic [1:0] state_a;

  logic       pix_valid_b, frame_start_b, frame_odd_b, line_start_b;
  logic       frame_done_b, marker_err_b, len_err_b;
  logic [4:0] pix_y_b, pix_c_b;
  logic [5:0] pix_x_b;
  logic [9:0] pix_line_b;
  logic [1:0] state_b;

  slant_lane_deframer dut_a (
    .Cclk(Cclk), .rstn(rstn), .RxData(RxData), .RxStrobe(strobe_a),
    .pix_valid(pix_valid_a), .pix_y(pix_y_a), .pix_c(pix_c_a), .pix_x(pix_x_a),
    .pix_line(pix_line_a), .frame_start(frame_start_a), .frame_odd(frame_odd_a),
    .line_start(line_start_a), .frame_done(frame_done_a), .marker_err(marker_err_a),
    .len_err(len_err_a), .dbg_state(state_a)
  );

  slant_lane_deframer #(.PAIRS_PER_LINE(2), .LINES_PER_FRAME(2)) dut_b (
    .Cclk(Cclk), .rstn(rstn), .RxData(RxData), .RxStrobe(strobe_b),
    .pix_valid(pix_valid_b), .pix_y(pix_y_b), .pix_c(pix_c_b), .pix_x(pix_x_b),
    .pix_line(pix_line_b), .frame_start(frame_start_b), .frame_odd(frame_odd_b),
    .line_start(line_start_b), .frame_done(frame_done_b), .marker_err(marker_err_b),
    .len_err(len_err_b), .dbg_state(state_b)
  );

  // clock / reset
  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pv_a = 0, fd_a = 0, pv_b = 0, fd_b = 0;
  int gap  = 0;
  bit sel  = 1'b0;

  always @(negedge Cclk) begin
    if (pix_valid_a) got_q.push_back({pix_line_a, pix_x_a, pix_y_a, pix_c_a});
    pv_a = pv_a + 32'(pix_valid_a);
    fd_a = fd_a + 32'(frame_done_a);
    pv_b = pv_b + 32'(pix_valid_b);
    fd_b = fd_b + 32'(frame_done_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_pix(input int line, input int x, input int y, input int c);
    exp_q.push_back({10'(line), 6'(x), 5'(y), 5'(c)});
  endtask

  task automatic drain();
    logic [25:0] g, e;
    @(negedge Cclk); #1;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      check_eq("pix", 32'(g), 32'(e));
    end
    check_eq("pix_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // driver tasks: idle cycles (RxData noise, no strobe) precede each strobed symbol
  task automatic send(input logic [7:0] d);
    for (int i = 0; i < gap; i++) begin
      RxData = 8'($urandom_range(0, 255));
      @(posedge Cclk); #1;
    end
    RxData = d;
    if (sel) strobe_b = 1'b1;
    else strobe_a = 1'b1;
    @(posedge Cclk); #1;
    strobe_a = 1'b0;
    strobe_b = 1'b0;
  endtask

  task automatic send_marker(input logic [23:0] m, input int n);
    for (int i = n - 1; i >= 0; i--) send(m[i] ? 8'hFF : 8'h01);
  endtask

  task automatic send_dat(input logic [4:0] p);
    send({1'b0, p, 2'b00});
  endtask

  initial begin
    int s_pv, s_fd;
    rstn = 1'b0; RxData = 8'h00; strobe_a = 1'b0; strobe_b = 1'b0;
    repeat (3) @(posedge Cclk);
    #1;
    check_eq("rst_pix_a", 32'({pix_valid_a, pix_y_a, pix_c_a, pix_x_a, pix_line_a}), 32'd0);
    check_eq("rst_flags_a", 32'({frame_start_a, frame_odd_a, line_start_a, frame_done_a,
                                 marker_err_a, len_err_a, state_a}), 32'd0);
    check_eq("rst_flags_b", 32'({pix_valid_b, frame_start_b, frame_odd_b, line_start_b,
                                 frame_done_b, marker_err_b, len_err_b, state_b}), 32'd0);
    rstn = 1'b1;

    // partial frame then mid-stream reset
    send_marker(F1, 24);
    send_dat(5'd5);
    send_dat(5'd9);
    push_pix(0, 0, 5, 9);
    drain();
    check_eq("odd_before_rst", 32'(frame_odd_a), 32'd1);
    s_fd = fd_a;
    send_dat(5'd3);
    rstn = 1'b0;
    repeat (3) @(posedge Cclk);
    #1;
    check_eq("mid_rst_pix", 32'({pix_valid_a, pix_y_a, pix_c_a, pix_x_a, pix_line_a}), 32'd0);
    check_eq("mid_rst_odd_state", 32'({frame_odd_a, state_a}), 32'd0);
    rstn = 1'b1;
    s_pv = pv_a;
    for (int i = 0; i < 6; i++) send_dat(5'(i * 7));
    drain();
    check_eq("no_marker_no_pix", 32'(pv_a - s_pv), 32'd0);
    check_eq("no_marker_hunt", 32'(state_a), 32'd0);
    check_eq("rst_no_done", 32'(fd_a - s_fd), 32'd0);

    // frame start with FRAME1 and first pair
    s_pv = pv_a;
    send_marker(F1, 24);
    send_dat(5'd31);
    check_eq("f1_start", 32'({frame_start_a, frame_odd_a, marker_err_a}), 32'b110);
    check_eq("f1_state", 32'(state_a), 32'd2);
    send_dat(5'd16);
    push_pix(0, 0, 31, 16);
    check_eq("pix0", 32'({pix_valid_a, pix_y_a, pix_c_a, pix_x_a, pix_line_a}),
             32'({1'b1, 5'd31, 5'd16, 6'd0, 10'd0}));

    // rest of line 0
    for (int x = 1; x < 40; x++) begin
      send_dat(5'((x * 3) % 32));
      send_dat(5'((x * 5 + 7) % 32));
      push_pix(0, x, (x * 3) % 32, (x * 5 + 7) % 32);
    end
    drain();
    check_eq("line0_count", 32'(pv_a - s_pv), 32'd40);

    // overrun symbol then HSYNC
    send_dat(5'd3);
    check_eq("overrun", 32'({len_err_a, pix_valid_a}), 32'b10);
    send_marker(HS, 16);
    send_dat(5'd12);
    check_eq("hsync", 32'({line_start_a, len_err_a, marker_err_a}), 32'b100);
    send_dat(5'd20);
    push_pix(1, 0, 12, 20);
    check_eq("line1_pix", 32'({pix_valid_a, pix_x_a, pix_line_a}), 32'({1'b1, 6'd0, 10'd1}));

    // widely spaced symbols with noise on RxData
    gap = 25;
    send_dat(5'd1);
    check_eq("gap_half", 32'(pix_valid_a), 32'd0);
    send_dat(5'd30);
    push_pix(1, 1, 1, 30);
    check_eq("gap_pix", 32'({pix_valid_a, pix_y_a, pix_c_a, pix_x_a}),
             32'({1'b1, 5'd1, 5'd30, 6'd1}));
    gap = 0;
    drain();

    // new FRAME0 aborts frame; HSYNC mid-pair
    s_pv = pv_a;
    s_fd = fd_a;
    send_marker(F0, 24);
    send_dat(5'd2);
    check_eq("f0_start", 32'({frame_start_a, frame_odd_a}), 32'b10);
    send_dat(5'd4);
    push_pix(0, 0, 2, 4);
    send_dat(5'd6);
    send(8'hFF);
    check_eq("half_pair_len", 32'(len_err_a), 32'd1);
    check_eq("half_pair_cnt", 32'(pv_a - s_pv), 32'd1);
    send_marker(HS, 15);
    send_dat(5'd8);
    check_eq("short_line", 32'({line_start_a, len_err_a}), 32'b11);
    send_dat(5'd10);
    push_pix(1, 0, 8, 10);
    drain();
    check_eq("abort_no_done", 32'(fd_a - s_fd), 32'd0);

    // marker errors
    send_marker(F1, 20);
    send_dat(5'd0);
    check_eq("short_run", 32'({marker_err_a, frame_start_a, state_a}), 32'b1000);
    send(8'hFF);
    send(8'h83);
    check_eq("ill_in_mark", 32'({marker_err_a, state_a}), 32'b100);
    send_marker(HS, 16);
    send_dat(5'd1);
    check_eq("hsync_outside", 32'({marker_err_a, line_start_a}), 32'b10);
    send_marker(F1, 24);
    send_dat(5'd7);
    send(8'h83);
    check_eq("ill_in_data", 32'({marker_err_a, state_a}), 32'b100);
    send_dat(5'd9);
    send_dat(5'd11);
    drain();

    // 2x2 lane: complete frame
    sel = 1'b1;
    s_pv = pv_b;
    s_fd = fd_b;
    send_marker(F0, 24);
    send_dat(5'd1);
    check_eq("b_start", 32'({frame_start_b, frame_odd_b}), 32'b10);
    send_dat(5'd2);
    check_eq("b_pix0", 32'({pix_valid_b, pix_y_b, pix_c_b, pix_x_b, pix_line_b}),
             32'({1'b1, 5'd1, 5'd2, 6'd0, 10'd0}));
    send_dat(5'd3);
    send_dat(5'd4);
    check_eq("b_pix1", 32'({pix_valid_b, pix_x_b, pix_c_b, frame_done_b}),
             32'({1'b1, 6'd1, 5'd4, 1'b0}));
    send_marker(HS, 16);
    send_dat(5'd5);
    check_eq("b_hsync", 32'({line_start_b, len_err_b}), 32'b10);
    send_dat(5'd6);
    check_eq("b_pix2", 32'({pix_valid_b, pix_line_b, pix_x_b, frame_done_b}),
             32'({1'b1, 10'd1, 6'd0, 1'b0}));
    send_dat(5'd7);
    send_dat(5'd8);
    check_eq("b_done", 32'({pix_valid_b, frame_done_b, pix_line_b, pix_x_b, pix_y_b, pix_c_b}),
             32'({1'b1, 1'b1, 10'd1, 6'd1, 5'd7, 5'd8}));
    check_eq("b_hunt", 32'(state_b), 32'd0);
    send_dat(5'd9);
    send_dat(5'd10);
    @(negedge Cclk); #1;
    check_eq("b_pix_count", 32'(pv_b - s_pv), 32'd4);
    check_eq("b_done_count", 32'(fd_b - s_fd), 32'd1);
    sel = 1'b0;

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
